// File: rtl/arb_pkg.sv
// Shared definitions for the eight-requester arbiter.
//   NREQ / IDW   : requester count and index width
//   arb_state_t  : arbiter control state
//   ptr_dec      : mod-8 decrement used to rotate the round-robin pointer
package arb_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDW  = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // 0 wraps to 7 through natural 3-bit modulo arithmetic
  function automatic logic [IDW-1:0] ptr_dec(input logic [IDW-1:0] p);
    return p - IDW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_prio_enc8.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
//   req : request vector to encode
//   idx : index of the highest set bit (0 when none set)
//   any : at least one bit of req is set
module prio_enc8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Ascending scan: the last set bit seen is the highest one
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        idx = IDW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester arbiter with fixed-priority and round-robin modes and an
// optional grant hold limit. All outputs are registered.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   mode      : 0 = fixed priority (7 highest), 1 = round robin
//   req       : per-client request levels
//   gnt       : one-hot grant, zero when idle
//   gnt_id    : binary index of granted client (holds last value when idle)
//   gnt_valid : gnt is non-zero
//   timeout   : one-cycle pulse when a grant is revoked by MAX_HOLD
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  // Counter stops here; with no limit it simply saturates at all-ones
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  arb_state_t        state;
  logic [IDW-1:0]    ptr;
  logic [HOLD_W-1:0] hold;

  logic [IDW-1:0]    top;
  logic [IDW-1:0]    shift;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    enc_idx;
  logic              enc_any;
  logic [IDW-1:0]    winner;
  logic              held;
  logic              at_limit;

  // Fixed mode behaves as round robin with the pointer pinned at 7
  assign top   = mode ? ptr : IDW'(NREQ - 1);
  assign shift = IDW'(NREQ - 1) - top;

  // Rotate so that req[top] lands on bit 7; the highest-index encode then
  // follows the descending wrap order top, top-1, ..., top+1
  always_comb begin
    req_rot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_rot[IDW'(i) + shift] = req[i];
    end
  end

  prio_enc8 u_enc (
    .req (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Undo the rotation: position j maps back to j - shift = j + top + 1
  assign winner   = enc_idx + top + IDW'(1);

  assign held     = req[gnt_id];
  assign at_limit = (MAX_HOLD != 0) && (hold == HOLD_SAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= IDW'(NREQ - 1);
      hold      <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enc_any) begin
            gnt       <= NREQ'(1) << winner;
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            hold      <= HOLD_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!held || at_limit) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold      <= '0;
            ptr       <= ptr_dec(gnt_id);
            state     <= IDLE;
            // Only a revocation of a still-held grant is a timeout;
            // a release on the limit cycle takes precedence
            timeout   <= held;
          end else if (hold != HOLD_SAT) begin
            hold <= hold + HOLD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(
    .MAX_HOLD (4),
    .HOLD_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned w;
    rst_n = 1'b0;
    mode  = 1'b0;
    req   = 8'h00;
    step();
    step();
    rst_n = 1'b1;

    // Reset values
    chk("rst_ptr",  32'(dut.ptr), 32'd7);
    chk("rst_hold", 32'(dut.hold), 32'd0);
    chk("rst_id",   32'(gnt_id), 32'd0);

    // Idle with no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_gnt",   32'(gnt), 32'h00);
      chk("idle_valid", 32'(gnt_valid), 32'd0);
      chk("idle_tmo",   32'(timeout), 32'd0);
      chk("idle_state", 32'(dut.state), 32'(arb_pkg::IDLE));
    end

    // Fixed priority: 0x2A -> 5, then 3
    mode = 1'b0;
    req  = 8'h2A;
    step();
    chk("fix_gnt5",   32'(gnt), 32'h20);
    chk("fix_id5",    32'(gnt_id), 32'd5);
    chk("fix_valid5", 32'(gnt_valid), 32'd1);
    req = 8'h0A;
    step();
    chk("fix_drop_gnt",   32'(gnt), 32'h00);
    chk("fix_drop_valid", 32'(gnt_valid), 32'd0);
    chk("fix_drop_id",    32'(gnt_id), 32'd5);
    step();
    chk("fix_gnt3", 32'(gnt), 32'h08);
    chk("fix_id3",  32'(gnt_id), 32'd3);
    req = 8'h00;
    step();
    chk("fix_rel3", 32'(gnt), 32'h00);
    chk("fix_ptr",  32'(dut.ptr), 32'd2);
    step();

    // Round robin with all requesting: 7,6,...,0,7
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    step();
    w = 7;
    for (int i = 0; i < 9; i++) begin
      chk("rr_gnt",  32'(gnt), 32'(8'h01 << w));
      chk("rr_id",   32'(gnt_id), 32'(w));
      step();
      chk("rr_hold", 32'(gnt), 32'(8'h01 << w));
      req = 8'hFF & ~(8'h01 << w);
      step();
      chk("rr_gap",  32'(gnt_valid), 32'd0);
      req = 8'hFF;
      step();
      w = (w + 7) % 8;
    end
    req = 8'h00;
    step();
    chk("rr_end", 32'(gnt), 32'h00);
    step();

    // Hold limit: 0x01 held for exactly 4 cycles, then timeout
    do_reset();
    mode = 1'b1;
    req  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lim_gnt", 32'(gnt), 32'h01);
      chk("lim_tmo", 32'(timeout), 32'd0);
    end
    step();
    chk("lim_revoke_gnt", 32'(gnt), 32'h00);
    chk("lim_revoke_tmo", 32'(timeout), 32'd1);
    step();
    chk("lim_regnt",     32'(gnt), 32'h01);
    chk("lim_tmo_pulse", 32'(timeout), 32'd0);

    // Release on the limit cycle: no timeout
    step();
    step();
    step();
    chk("sim_gnt4", 32'(gnt), 32'h01);
    req = 8'h00;
    step();
    chk("sim_gnt", 32'(gnt), 32'h00);
    chk("sim_tmo", 32'(timeout), 32'd0);
    step();

    // Reset mid-grant restores ptr to 7
    do_reset();
    mode = 1'b1;
    req  = 8'h40;
    step();
    chk("mid_gnt6a", 32'(gnt), 32'h40);
    req = 8'h00;
    step();
    chk("mid_ptr5", 32'(dut.ptr), 32'd5);
    req = 8'h40;
    step();
    chk("mid_gnt6b", 32'(gnt), 32'h40);
    rst_n = 1'b0;
    step();
    chk("mid_rst_gnt",   32'(gnt), 32'h00);
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    chk("mid_rst_ptr",   32'(dut.ptr), 32'd7);
    rst_n = 1'b1;
    req   = 8'h41;
    step();
    chk("post_rst_id",  32'(gnt_id), 32'd6);
    chk("post_rst_gnt", 32'(gnt), 32'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester arbiter that shares one downstream resource, such as a bus port or a shared datapath slot, between up to eight clients. It resolves contention with an 8-to-3 priority encode and holds each grant until the winner releases it or a hold limit expires. It supports fixed-priority and round-robin modes. It sits between the requesting blocks and the shared resource, and drives the resource's select/index lines from `gnt_id`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a grant may be held; 0 disables the limit.
- `HOLD_W`, default 5: hold-counter width; must satisfy 2^HOLD_W > MAX_HOLD.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `mode` input 1: 0 = fixed priority (index 7 highest), 1 = round robin.
- `req` input 8: per-client request level; a client holds it high for as long as it wants the resource.
- `gnt` output 8: one-hot grant, registered; all zero when idle.
- `gnt_id` output 3: binary index of the granted client; valid while `gnt_valid`=1.
- `gnt_valid` output 1: high exactly when `gnt` is non-zero.
- `timeout` output 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- States: IDLE, GRANT.
- Pointer `ptr` (3 bits) holds the top-priority index. The search order is descending with wrap: ptr, ptr-1, …, 0, 7, …, ptr+1.
- Fixed mode: `ptr` is ignored and the search always starts at 7. The result equals a plain highest-index-wins priority encode.
- **IDLE:**
  - If `req` = 0, stay in IDLE.
  - Otherwise select winner k by the search order.
  - Next cycle: `gnt` = 1<<k, `gnt_id` = k, `gnt_valid` = 1, state goes to GRANT, hold counter = 1.
- **GRANT, normal release:**
  - If `req[gnt_id]` is sampled low, clear `gnt`/`gnt_valid` next cycle and go to IDLE.
  - `ptr` ← `gnt_id` − 1 (mod 8), with 0 wrapping to 7.
  - `gnt_id` retains its last value.
- **GRANT, hold limit:**
  - If `MAX_HOLD` ≠ 0 and the hold counter equals `MAX_HOLD` while `req[gnt_id]` is still high, revoke the grant.
  - Next cycle: `gnt` = 0, `timeout` = 1 for one cycle, state goes to IDLE, `ptr` advances as above.
  - The revoked client recompetes normally and is not masked.
- **GRANT, other cycles:** the hold counter increments and saturates at `MAX_HOLD`.
- Requests from non-granted clients during GRANT are ignored, with no queuing. They are evaluated on the next IDLE cycle.
- Release and limit in the same cycle: normal release wins and `timeout` stays 0.
- `mode` is sampled only in IDLE. Changing it during GRANT has no effect on the current grant.
- Reset:
  - Asserted mid-grant, it drops `gnt` on the next edge.
  - Reset values: state IDLE, `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0, `ptr` = 7, hold counter = 0.

## Timing
- Request to grant: 1 cycle, with `req` sampled at edge N and `gnt` high after edge N.
- Release to grant drop: 1 cycle.
- There is always at least one IDLE cycle between consecutive grants, so hand-over is 2 cycles after the release is sampled.
- With `MAX_HOLD` = M, `gnt` stays high for exactly M cycles.
- All outputs are registered; there are no combinational paths from `req` to outputs.

## Structure
- Shared package `arb_pkg` holds:
  - `NREQ` = 8 and `IDW` = 3 constants.
  - State enum `arb_state_t {IDLE, GRANT}`.
  - A function for mod-8 pointer decrement.
- Sub-module `prio_enc8`: combinational 8→3 highest-index encoder with an `any` flag.
  - Instantiated once on the request vector rotated by (7 − `ptr`).
  - The result is un-rotated to give k.

## Test plan
- Reset, then `req`=0x00: all outputs 0, state IDLE for 10 cycles.
- Fixed mode, `req`=0x2A:
  - `gnt`=0x20 and `gnt_id`=5 one cycle later.
  - Drop `req[5]`: `gnt`=0 next cycle, then `gnt`=0x08 (`gnt_id`=3) the cycle after.
- Round robin, `req`=0xFF held, with each winner dropping its `req` for one cycle after 2 cycles of grant: grant order 7,6,5,…,0,7.
- `MAX_HOLD`=4, `req`=0x01 held:
  - `gnt`=0x01 for exactly 4 cycles, `timeout` pulses once.
  - One idle cycle, then re-grant to 0.
- Simultaneous release and limit on cycle 4: `timeout` stays 0.
- `rst_n` low during GRANT (`gnt`=0x40): next edge `gnt`=0, `ptr`=7. After reset, `req`=0x41 in RR mode gives `gnt_id`=6.
